// File: rtl/rs_pkg.sv
// Shared types and constants for the integer-ALU reservation station.
// The entry struct sizes its tag fields with ROB_ID_W_DEFAULT, so rs_alu's
// ROB_ID_W must equal that value.
package rs_pkg;

    localparam int RS_DEPTH_DEFAULT = 8;
    localparam int ROB_ID_W_DEFAULT = 5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic                        valid;
        logic [6:0]                  op;
        logic [2:0]                  funct3;
        logic [6:0]                  funct7;
        logic [31:0]                 imm;
        logic [31:0]                 pc;
        logic [ROB_ID_W_DEFAULT-1:0] rob_id;
        logic                        qj_busy;
        logic [ROB_ID_W_DEFAULT-1:0] qj;
        logic [31:0]                 vj;
        logic                        qk_busy;
        logic [ROB_ID_W_DEFAULT-1:0] qk;
        logic [31:0]                 vk;
    } rs_entry_t;

endpackage

// File: rtl/rs_select.sv
// Lowest-index priority encoder: reports whether any request bit is set and
// the index of the lowest one.
module rs_select #(
    parameter int N = 8
) (
    input  logic [N-1:0]         req,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IDX_W = $clog2(N);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = N; i > 0; i--) begin
            if (req[i-1]) begin
                found = 1'b1;
                idx   = IDX_W'(i - 1);
            end
        end
    end

endmodule

// File: rtl/rs_alu.sv
// Reservation station for the integer ALU: holds dispatched instructions,
// captures pending operands from the CDB and issues the lowest-index ready
// entry to the ALU each cycle.
// Optional feature: define RS_BYPASS_EN to let a CDB broadcast make a pending
// operand ready (and supply its value) in the same cycle.
module rs_alu
    import rs_pkg::*;
#(
    parameter int RS_DEPTH = RS_DEPTH_DEFAULT,
    parameter int ROB_ID_W = ROB_ID_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear_i,
    input  logic                issue_en_i,
    input  logic [6:0]          issue_op_i,
    input  logic [2:0]          issue_funct3_i,
    input  logic [6:0]          issue_funct7_i,
    input  logic [31:0]         issue_imm_i,
    input  logic [31:0]         issue_pc_i,
    input  logic [ROB_ID_W-1:0] issue_rob_id_i,
    input  logic                issue_qj_busy_i,
    input  logic                issue_qk_busy_i,
    input  logic [ROB_ID_W-1:0] issue_qj_i,
    input  logic [ROB_ID_W-1:0] issue_qk_i,
    input  logic [31:0]         issue_vj_i,
    input  logic [31:0]         issue_vk_i,
    output logic                full_o,
    input  logic                cdb_en_i,
    input  logic [ROB_ID_W-1:0] cdb_id_ROB_i,
    input  logic [31:0]         cdb_data_i,
    output logic                ex_en_o,
    output logic [31:0]         ex_A_o,
    output logic [31:0]         ex_B_o,
    output logic [31:0]         ex_Imm_o,
    output logic [31:0]         ex_pc_o,
    output logic [6:0]          ex_OP_o,
    output logic [6:0]          ex_Funct7_o,
    output logic [2:0]          ex_Funct3_o,
    output logic [ROB_ID_W-1:0] ex_ROB_id_o
);

    localparam int IDX_W = $clog2(RS_DEPTH);

    rs_entry_t           ent [RS_DEPTH];
    rs_entry_t           new_ent;
    rs_entry_t           sel;
    logic [RS_DEPTH-1:0] valid_vec;
    logic [RS_DEPTH-1:0] ready_vec;
    logic                free_found;
    logic [IDX_W-1:0]    free_idx;
    logic                rdy_found;
    logic [IDX_W-1:0]    rdy_idx;
    logic                cap_j;
    logic                cap_k;
    logic [31:0]         sel_a;
    logic [31:0]         sel_b;

    // Per-entry valid and ready vectors feeding the two priority encoders.
    always_comb begin
        valid_vec = '0;
        ready_vec = '0;
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
            valid_vec[i] = ent[i].valid;
`ifdef RS_BYPASS_EN
            ready_vec[i] = ent[i].valid
                && (!ent[i].qj_busy || (cdb_en_i && ent[i].qj == cdb_id_ROB_i))
                && (!ent[i].qk_busy || (cdb_en_i && ent[i].qk == cdb_id_ROB_i));
`else
            ready_vec[i] = ent[i].valid && !ent[i].qj_busy && !ent[i].qk_busy;
`endif
        end
    end

    assign full_o = &valid_vec;

    rs_select #(.N(RS_DEPTH)) u_free_sel (
        .req   (~valid_vec),
        .found (free_found),
        .idx   (free_idx)
    );

    rs_select #(.N(RS_DEPTH)) u_rdy_sel (
        .req   (ready_vec),
        .found (rdy_found),
        .idx   (rdy_idx)
    );

    // Incoming entry, with operands captured from a same-cycle CDB broadcast.
    always_comb begin
        cap_j = issue_qj_busy_i && cdb_en_i && (issue_qj_i == cdb_id_ROB_i);
        cap_k = issue_qk_busy_i && cdb_en_i && (issue_qk_i == cdb_id_ROB_i);
        new_ent         = '0;
        new_ent.valid   = 1'b1;
        new_ent.op      = issue_op_i;
        new_ent.funct3  = issue_funct3_i;
        new_ent.funct7  = issue_funct7_i;
        new_ent.imm     = issue_imm_i;
        new_ent.pc      = issue_pc_i;
        new_ent.rob_id  = issue_rob_id_i;
        new_ent.qj_busy = issue_qj_busy_i && !cap_j;
        new_ent.qj      = issue_qj_i;
        new_ent.vj      = cap_j ? cdb_data_i : issue_vj_i;
        new_ent.qk_busy = issue_qk_busy_i && !cap_k;
        new_ent.qk      = issue_qk_i;
        new_ent.vk      = cap_k ? cdb_data_i : issue_vk_i;
    end

    // Operand mux for the selected entry; a still-busy operand on a ready
    // entry can only occur through the CDB bypass.
    always_comb begin
        sel = ent[rdy_idx];
`ifdef RS_BYPASS_EN
        sel_a = sel.qj_busy ? cdb_data_i : sel.vj;
        sel_b = sel.qk_busy ? cdb_data_i : sel.vk;
`else
        sel_a = sel.vj;
        sel_b = sel.vk;
`endif
    end

    // Entry storage and registered ALU-stage outputs. The issue target is
    // chosen from pre-edge valid bits, so it never aliases the entry being
    // dispatched in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < RS_DEPTH; i++) begin
                ent[i] <= '0;
            end
            ex_en_o     <= 1'b0;
            ex_A_o      <= '0;
            ex_B_o      <= '0;
            ex_Imm_o    <= '0;
            ex_pc_o     <= '0;
            ex_OP_o     <= '0;
            ex_Funct7_o <= '0;
            ex_Funct3_o <= '0;
            ex_ROB_id_o <= '0;
        end else if (clear_i) begin
            for (int unsigned i = 0; i < RS_DEPTH; i++) begin
                ent[i].valid <= 1'b0;
            end
            ex_en_o     <= 1'b0;
            ex_A_o      <= '0;
            ex_B_o      <= '0;
            ex_Imm_o    <= '0;
            ex_pc_o     <= '0;
            ex_OP_o     <= '0;
            ex_Funct7_o <= '0;
            ex_Funct3_o <= '0;
            ex_ROB_id_o <= '0;
        end else begin
            for (int unsigned i = 0; i < RS_DEPTH; i++) begin
                if (ent[i].valid && cdb_en_i) begin
                    if (ent[i].qj_busy && ent[i].qj == cdb_id_ROB_i) begin
                        ent[i].vj      <= cdb_data_i;
                        ent[i].qj_busy <= 1'b0;
                    end
                    if (ent[i].qk_busy && ent[i].qk == cdb_id_ROB_i) begin
                        ent[i].vk      <= cdb_data_i;
                        ent[i].qk_busy <= 1'b0;
                    end
                end
            end

            if (rdy_found) begin
                ent[rdy_idx].valid <= 1'b0;
                ex_en_o     <= 1'b1;
                ex_A_o      <= sel_a;
                ex_B_o      <= sel_b;
                ex_Imm_o    <= sel.imm;
                ex_pc_o     <= sel.pc;
                ex_OP_o     <= sel.op;
                ex_Funct7_o <= sel.funct7;
                ex_Funct3_o <= sel.funct3;
                ex_ROB_id_o <= sel.rob_id;
            end else begin
                ex_en_o     <= 1'b0;
                ex_A_o      <= '0;
                ex_B_o      <= '0;
                ex_Imm_o    <= '0;
                ex_pc_o     <= '0;
                ex_OP_o     <= '0;
                ex_Funct7_o <= '0;
                ex_Funct3_o <= '0;
                ex_ROB_id_o <= '0;
            end

            if (issue_en_i && free_found) begin
                ent[free_idx] <= new_ent;
            end
        end
    end

endmodule

// File: tb/tb_rs_alu.sv
// Directed self-checking bench for rs_alu. Expected latencies follow the
// RS_BYPASS_EN setting of the build.
module tb_rs_alu;
    import rs_pkg::*;

    localparam int DEPTH = 8;
    localparam int RW    = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear_i;
    logic          issue_en_i;
    logic [6:0]    issue_op_i;
    logic [2:0]    issue_funct3_i;
    logic [6:0]    issue_funct7_i;
    logic [31:0]   issue_imm_i;
    logic [31:0]   issue_pc_i;
    logic [RW-1:0] issue_rob_id_i;
    logic          issue_qj_busy_i;
    logic          issue_qk_busy_i;
    logic [RW-1:0] issue_qj_i;
    logic [RW-1:0] issue_qk_i;
    logic [31:0]   issue_vj_i;
    logic [31:0]   issue_vk_i;
    logic          full_o;
    logic          cdb_en_i;
    logic [RW-1:0] cdb_id_ROB_i;
    logic [31:0]   cdb_data_i;
    logic          ex_en_o;
    logic [31:0]   ex_A_o;
    logic [31:0]   ex_B_o;
    logic [31:0]   ex_Imm_o;
    logic [31:0]   ex_pc_o;
    logic [6:0]    ex_OP_o;
    logic [6:0]    ex_Funct7_o;
    logic [2:0]    ex_Funct3_o;
    logic [RW-1:0] ex_ROB_id_o;

    int n_tests = 0;
    int n_fail  = 0;

    rs_alu #(.RS_DEPTH(DEPTH), .ROB_ID_W(RW)) dut (
        .clk             (clk),
        .rst             (rst),
        .clear_i         (clear_i),
        .issue_en_i      (issue_en_i),
        .issue_op_i      (issue_op_i),
        .issue_funct3_i  (issue_funct3_i),
        .issue_funct7_i  (issue_funct7_i),
        .issue_imm_i     (issue_imm_i),
        .issue_pc_i      (issue_pc_i),
        .issue_rob_id_i  (issue_rob_id_i),
        .issue_qj_busy_i (issue_qj_busy_i),
        .issue_qk_busy_i (issue_qk_busy_i),
        .issue_qj_i      (issue_qj_i),
        .issue_qk_i      (issue_qk_i),
        .issue_vj_i      (issue_vj_i),
        .issue_vk_i      (issue_vk_i),
        .full_o          (full_o),
        .cdb_en_i        (cdb_en_i),
        .cdb_id_ROB_i    (cdb_id_ROB_i),
        .cdb_data_i      (cdb_data_i),
        .ex_en_o         (ex_en_o),
        .ex_A_o          (ex_A_o),
        .ex_B_o          (ex_B_o),
        .ex_Imm_o        (ex_Imm_o),
        .ex_pc_o         (ex_pc_o),
        .ex_OP_o         (ex_OP_o),
        .ex_Funct7_o     (ex_Funct7_o),
        .ex_Funct3_o     (ex_Funct3_o),
        .ex_ROB_id_o     (ex_ROB_id_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clear_i         = 1'b0;
        issue_en_i      = 1'b0;
        issue_op_i      = '0;
        issue_funct3_i  = '0;
        issue_funct7_i  = '0;
        issue_imm_i     = '0;
        issue_pc_i      = '0;
        issue_rob_id_i  = '0;
        issue_qj_busy_i = 1'b0;
        issue_qk_busy_i = 1'b0;
        issue_qj_i      = '0;
        issue_qk_i      = '0;
        issue_vj_i      = '0;
        issue_vk_i      = '0;
        cdb_en_i        = 1'b0;
        cdb_id_ROB_i    = '0;
        cdb_data_i      = '0;
    endtask

    task automatic put(input logic [6:0] op, input logic [31:0] imm, input logic [RW-1:0] rob,
                       input logic qjb, input logic [RW-1:0] qj, input logic [31:0] vj,
                       input logic qkb, input logic [RW-1:0] qk, input logic [31:0] vk);
        issue_en_i      = 1'b1;
        issue_op_i      = op;
        issue_funct3_i  = 3'd0;
        issue_funct7_i  = 7'd0;
        issue_imm_i     = imm;
        issue_pc_i      = 32'h1000 + 32'(rob) * 4;
        issue_rob_id_i  = rob;
        issue_qj_busy_i = qjb;
        issue_qj_i      = qj;
        issue_vj_i      = vj;
        issue_qk_busy_i = qkb;
        issue_qk_i      = qk;
        issue_vk_i      = vk;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        #12;
        check("reset_ex_en", 32'(ex_en_o), 32'd0);
        check("reset_full", 32'(full_o), 32'd0);
        check("reset_ex_A", ex_A_o, 32'd0);
        check("reset_ex_rob", 32'(ex_ROB_id_o), 32'd0);
        rst = 1'b1;
        tick();

        // Ready issue: ADDI rob 3, vj=5, imm=7
        put(OPC_OP_IMM, 32'd7, 5'd3, 1'b0, 5'd0, 32'd5, 1'b0, 5'd0, 32'd0);
        tick();
        check("ready_e0_no_dispatch", 32'(ex_en_o), 32'd0);
        idle();
        tick();
        check("ready_ex_en", 32'(ex_en_o), 32'd1);
        check("ready_ex_A", ex_A_o, 32'd5);
        check("ready_ex_imm", ex_Imm_o, 32'd7);
        check("ready_ex_rob", 32'(ex_ROB_id_o), 32'd3);
        check("ready_ex_op", 32'(ex_OP_o), 32'(OPC_OP_IMM));
        check("ready_ex_pc", ex_pc_o, 32'h100c);
        tick();
        check("ready_idle_ex_en", 32'(ex_en_o), 32'd0);
        check("ready_idle_ex_A", ex_A_o, 32'd0);

        // Wakeup: ADD rob 4, qj=2 pending, vk=10
        put(OPC_OP, 32'd0, 5'd4, 1'b1, 5'd2, 32'd0, 1'b0, 5'd0, 32'd10);
        tick();
        idle();
        tick();
        check("wake_wait_ex_en", 32'(ex_en_o), 32'd0);
        cdb_en_i = 1'b1; cdb_id_ROB_i = 5'd2; cdb_data_i = 32'h20;
        tick();
        idle();
`ifndef RS_BYPASS_EN
        check("wake_ec_no_dispatch", 32'(ex_en_o), 32'd0);
        tick();
`endif
        check("wake_ex_en", 32'(ex_en_o), 32'd1);
        check("wake_ex_A", ex_A_o, 32'h20);
        check("wake_ex_B", ex_B_o, 32'd10);
        check("wake_ex_rob", 32'(ex_ROB_id_o), 32'd4);
        tick();
        check("wake_done", 32'(ex_en_o), 32'd0);

        // Issue-time capture: qj=6 pending with CDB id 6 data 9 same cycle
        put(OPC_OP, 32'd0, 5'd5, 1'b1, 5'd6, 32'd0, 1'b0, 5'd0, 32'd1);
        cdb_en_i = 1'b1; cdb_id_ROB_i = 5'd6; cdb_data_i = 32'd9;
        tick();
        idle();
        tick();
        check("capture_ex_en", 32'(ex_en_o), 32'd1);
        check("capture_ex_A", ex_A_o, 32'd9);
        check("capture_ex_rob", 32'(ex_ROB_id_o), 32'd5);
        tick();

        // Full: DEPTH entries waiting on tag 7
        for (int i = 0; i < DEPTH; i++) begin
            check("fill_not_full", 32'(full_o), 32'd0);
            put(OPC_OP, 32'd0, RW'(8 + i), 1'b1, 5'd7, 32'd0, 1'b0, 5'd0, 32'(i));
            tick();
        end
        check("full_set", 32'(full_o), 32'd1);
        put(OPC_OP, 32'd0, 5'd31, 1'b0, 5'd0, 32'd1, 1'b0, 5'd0, 32'd1);
        tick();
        check("full_ignored_ex_en", 32'(ex_en_o), 32'd0);
        check("full_still", 32'(full_o), 32'd1);
        idle();
        cdb_en_i = 1'b1; cdb_id_ROB_i = 5'd7; cdb_data_i = 32'h77;
        tick();
        idle();
`ifndef RS_BYPASS_EN
        check("full_ec_no_dispatch", 32'(ex_en_o), 32'd0);
        check("full_ec_full", 32'(full_o), 32'd1);
        tick();
`endif
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_ex_en", 32'(ex_en_o), 32'd1);
            check("drain_ex_rob", 32'(ex_ROB_id_o), 32'(8 + i));
            check("drain_ex_A", ex_A_o, 32'h77);
            check("drain_ex_B", ex_B_o, 32'(i));
            if (i == 0) check("drain_full_drop", 32'(full_o), 32'd0);
            tick();
        end
        check("drain_no_ignored", 32'(ex_en_o), 32'd0);

        // Flush: 4 pending entries, then clear with simultaneous issue and CDB
        for (int i = 0; i < 4; i++) begin
            put(OPC_OP, 32'd0, RW'(20 + i), 1'b1, 5'd1, 32'd0, 1'b0, 5'd0, 32'd0);
            tick();
        end
        put(OPC_OP_IMM, 32'd0, 5'd24, 1'b0, 5'd0, 32'd3, 1'b0, 5'd0, 32'd0);
        cdb_en_i = 1'b1; cdb_id_ROB_i = 5'd1; cdb_data_i = 32'd5;
        clear_i  = 1'b1;
        tick();
        idle();
        check("flush_ex_en", 32'(ex_en_o), 32'd0);
        check("flush_full", 32'(full_o), 32'd0);
        cdb_en_i = 1'b1; cdb_id_ROB_i = 5'd1; cdb_data_i = 32'd5;
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            check("flush_no_dispatch", 32'(ex_en_o), 32'd0);
            tick();
        end

        // Reset mid-operation
        for (int i = 0; i < 3; i++) begin
            put(OPC_OP, 32'd0, RW'(10 + i), 1'b1, 5'd3, 32'd0, 1'b0, 5'd0, 32'd0);
            tick();
        end
        put(OPC_OP_IMM, 32'd0, 5'd30, 1'b0, 5'd0, 32'd4, 1'b0, 5'd0, 32'd0);
        tick();
        idle();
        tick();
        check("pre_rst_ex_en", 32'(ex_en_o), 32'd1);
        check("pre_rst_ex_rob", 32'(ex_ROB_id_o), 32'd30);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_ex_en", 32'(ex_en_o), 32'd0);
        check("mid_rst_ex_A", ex_A_o, 32'd0);
        check("mid_rst_full", 32'(full_o), 32'd0);
        #3;
        rst = 1'b1;
        cdb_en_i = 1'b1; cdb_id_ROB_i = 5'd3; cdb_data_i = 32'd1;
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            check("post_rst_no_dispatch", 32'(ex_en_o), 32'd0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
